// File: rtl/vdg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vdg_pkg
// Brief    : Shared mode codes, event encoding and row-divisor decode for the
//            VDG address counter.
// Revision : 1.0 - initial release
// ============================================================================
package vdg_pkg;

   localparam int OFFSET_SHIFT = 9;

   localparam logic [2:0] c_MODE_ALPHA   = 3'd0;
   localparam logic [2:0] c_MODE_RG1     = 3'd1;
   localparam logic [2:0] c_MODE_RG2     = 3'd2;
   localparam logic [2:0] c_MODE_RG3     = 3'd3;
   localparam logic [2:0] c_MODE_RG4     = 3'd4;
   localparam logic [2:0] c_MODE_RG5     = 3'd5;
   localparam logic [2:0] c_MODE_RG6     = 3'd6;
   localparam logic [2:0] c_MODE_FULL    = 3'd7;

   // Only one event is acted on per cycle; this is the winner of the mux.
   typedef enum logic [1:0] {
      EVT_NONE  = 2'd0,
      EVT_FRAME = 2'd1,
      EVT_LINE  = 2'd2,
      EVT_FETCH = 2'd3
   } vdgEvent_e;

   function automatic logic [3:0] row_divisor(input logic [2:0] mode);
      logic [3:0] divisor;
      divisor = 4'd1;
      case (mode)
         c_MODE_ALPHA:           divisor = 4'd12;
         c_MODE_RG1, c_MODE_RG2: divisor = 4'd3;
         c_MODE_RG3, c_MODE_RG4: divisor = 4'd2;
         c_MODE_RG5, c_MODE_RG6,
         c_MODE_FULL:            divisor = 4'd1;
         default:                divisor = 4'd1;
      endcase
      return divisor;
   endfunction

endpackage : vdg_pkg
`default_nettype wire

// File: rtl/vdg_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : vdg_edge_sync
// Brief    : Multi-flop input synchroniser with registered falling-edge detect.
// Revision : 1.0 - initial release
// ============================================================================
module vdg_edge_sync
   import vdg_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
)(
   input  logic clk,
   input  logic rstN,
   input  logic din,
   output logic level,
   output logic fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_fall;
   logic                   w_cur;

   generate
      if (SYNC_STAGES == 1) begin : g_single
         always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
               r_sync <= RESET_VAL;
            end else begin
               r_sync <= din;
            end
         end
      end else begin : g_multi
         always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
               r_sync <= {SYNC_STAGES{RESET_VAL}};
            end else begin
               r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            end
         end
      end
   endgenerate

   assign w_cur = r_sync[SYNC_STAGES-1];

   // Prev resets to the idle level so release from reset never fakes an edge.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_prev <= RESET_VAL;
         r_fall <= 1'b0;
      end else begin
         r_prev <= w_cur;
         r_fall <= r_prev & ~w_cur;
      end
   end

   assign level = w_cur;
   assign fall  = r_fall;

endmodule : vdg_edge_sync
`default_nettype wire

// File: rtl/vdg_address_counter.sv
`default_nettype none
// ============================================================================
// Module   : vdg_address_counter
// Brief    : SAM-style display fetch address generator driven by DA0/HSn/FSn.
// Revision : 1.0 - initial release
// ============================================================================
module vdg_address_counter
   import vdg_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 16
)(
   input  logic              Clk,
   input  logic              RSTn,
   input  logic              DA0,
   input  logic              HSn,
   input  logic              FSn,
   input  logic [2:0]        VMode,
   input  logic [6:0]        Offset,
   output logic [ADDR_W-1:0] VAddr,
   output logic              FetchStrobe,
   output logic [3:0]        RowPhase,
   output logic              FrameStart
);

   logic              w_da0Fall;
   logic              w_hsFall;
   logic              w_fsFall;
   logic [2:0]        w_unusedLevel;
   vdgEvent_e         w_event;
   logic [3:0]        w_divisor;
   logic              w_rowEnd;
   logic [ADDR_W-1:0] w_frameBase;

   logic [ADDR_W-1:0] r_vAddr;
   logic [ADDR_W-1:0] r_lineBase;
   logic [3:0]        r_rowPhase;
   logic              r_fetchStrobe;
   logic              r_frameStart;

   vdg_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b0)
   ) u_da0Sync (
      .clk   (Clk),
      .rstN  (RSTn),
      .din   (DA0),
      .level (w_unusedLevel[0]),
      .fall  (w_da0Fall)
   );

   vdg_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b1)
   ) u_hsSync (
      .clk   (Clk),
      .rstN  (RSTn),
      .din   (HSn),
      .level (w_unusedLevel[1]),
      .fall  (w_hsFall)
   );

   vdg_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b1)
   ) u_fsSync (
      .clk   (Clk),
      .rstN  (RSTn),
      .din   (FSn),
      .level (w_unusedLevel[2]),
      .fall  (w_fsFall)
   );

   always_comb begin
      w_event = EVT_NONE;
      if (w_fsFall) begin
         w_event = EVT_FRAME;
      end else if (w_hsFall) begin
         w_event = EVT_LINE;
      end else if (w_da0Fall) begin
         w_event = EVT_FETCH;
      end
   end

   // >= rather than == so a divisor that shrinks mid-row still closes the row.
   assign w_divisor   = row_divisor(VMode);
   assign w_rowEnd    = (r_rowPhase >= (w_divisor - 4'd1));
   assign w_frameBase = ADDR_W'({Offset, {OFFSET_SHIFT{1'b0}}});

   always_ff @(posedge Clk or negedge RSTn) begin
      if (!RSTn) begin
         r_vAddr       <= '0;
         r_lineBase    <= '0;
         r_rowPhase    <= 4'd0;
         r_fetchStrobe <= 1'b0;
         r_frameStart  <= 1'b0;
      end else begin
         r_fetchStrobe <= 1'b0;
         r_frameStart  <= 1'b0;
         case (w_event)
            EVT_FRAME: begin
               r_vAddr      <= w_frameBase;
               r_lineBase   <= w_frameBase;
               r_rowPhase   <= 4'd0;
               r_frameStart <= 1'b1;
            end
            EVT_LINE: begin
               if (w_rowEnd) begin
                  r_rowPhase <= 4'd0;
                  r_lineBase <= r_vAddr;
               end else begin
                  r_rowPhase <= r_rowPhase + 4'd1;
                  r_vAddr    <= r_lineBase;
               end
            end
            EVT_FETCH: begin
               r_vAddr       <= r_vAddr + 1'b1;
               r_fetchStrobe <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign VAddr       = r_vAddr;
   assign FetchStrobe = r_fetchStrobe;
   assign RowPhase    = r_rowPhase;
   assign FrameStart  = r_frameStart;

endmodule : vdg_address_counter
`default_nettype wire

// File: tb/tb_vdg_address_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdg_address_counter
// Brief    : Directed self-checking bench for vdg_address_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdg_address_counter;

   logic        Clk = 1'b0;
   logic        RSTn = 1'b0;
   logic        DA0 = 1'b0;
   logic        HSn = 1'b1;
   logic        FSn = 1'b1;
   logic [2:0]  VMode = 3'd0;
   logic [6:0]  Offset = 7'h00;
   logic [15:0] VAddr;
   logic        FetchStrobe;
   logic [3:0]  RowPhase;
   logic        FrameStart;

   int nChecks = 0;
   int nFails  = 0;
   int strobeCnt = 0;
   int frameCnt = 0;
   int strobeBase;

   vdg_address_counter #(
      .SYNC_STAGES (2),
      .ADDR_W      (16)
   ) dut (
      .Clk         (Clk),
      .RSTn        (RSTn),
      .DA0         (DA0),
      .HSn         (HSn),
      .FSn         (FSn),
      .VMode       (VMode),
      .Offset      (Offset),
      .VAddr       (VAddr),
      .FetchStrobe (FetchStrobe),
      .RowPhase    (RowPhase),
      .FrameStart  (FrameStart)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (FetchStrobe) strobeCnt++;
      if (FrameStart)  frameCnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      repeat (6) @(negedge Clk);
   endtask

   task automatic da0Falls(input int n);
      repeat (n) begin
         @(negedge Clk) DA0 = 1'b1;
         @(negedge Clk) DA0 = 1'b0;
      end
      settle();
   endtask

   task automatic hsPulse();
      @(negedge Clk) HSn = 1'b0;
      repeat (3) @(negedge Clk);
      HSn = 1'b1;
      settle();
   endtask

   task automatic fsPulse();
      @(negedge Clk) FSn = 1'b0;
      repeat (3) @(negedge Clk);
      FSn = 1'b1;
      settle();
   endtask

   initial begin
      // Reset held with inputs toggling
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         DA0 = ~DA0;
         HSn = ~HSn;
         FSn = ~FSn;
         check("rst_vaddr", 32'(VAddr), 32'h0);
         check("rst_rowphase", 32'(RowPhase), 32'h0);
         check("rst_strobe", 32'(FetchStrobe), 32'h0);
         check("rst_framestart", 32'(FrameStart), 32'h0);
      end
      DA0 = 1'b0; HSn = 1'b1; FSn = 1'b1;
      settle();
      @(negedge Clk) RSTn = 1'b1;
      settle();

      // Frame reload latency: SYNC_STAGES+2 = 4 clocks
      Offset = 7'h02;
      @(negedge Clk) FSn = 1'b0;
      repeat (3) @(negedge Clk);
      check("frame_lat_early", 32'(FrameStart), 32'h0);
      @(negedge Clk);
      check("frame_lat_pulse", 32'(FrameStart), 32'h1);
      check("frame_vaddr", 32'(VAddr), 32'h0400);
      FSn = 1'b1;
      @(negedge Clk);
      check("frame_pulse_width", 32'(FrameStart), 32'h0);
      settle();
      check("frame_rowphase", 32'(RowPhase), 32'h0);

      // Fetch counting
      strobeBase = strobeCnt;
      da0Falls(32);
      check("fetch_strobes", 32'(strobeCnt - strobeBase), 32'd32);
      check("fetch_vaddr", 32'(VAddr), 32'h0420);

      // Alpha row repeat, VMode=0 (divisor 12)
      VMode = 3'd0;
      for (int k = 1; k <= 11; k++) begin
         if (k > 1) da0Falls(32);
         hsPulse();
         check($sformatf("alpha_rewind_vaddr_%0d", k), 32'(VAddr), 32'h0400);
         check($sformatf("alpha_rowphase_%0d", k), 32'(RowPhase), 32'(k));
      end
      da0Falls(32);
      hsPulse();
      check("alpha_end_vaddr", 32'(VAddr), 32'h0420);
      check("alpha_end_rowphase", 32'(RowPhase), 32'h0);
      da0Falls(32);
      check("alpha_next_fetch", 32'(VAddr), 32'h0440);
      hsPulse();
      check("alpha_next_rewind", 32'(VAddr), 32'h0420);
      check("alpha_next_rowphase", 32'(RowPhase), 32'h1);

      // Mode shrink mid-row: RowPhase 5 under divisor 12, then divisor 2
      repeat (4) hsPulse();
      check("shrink_pre_rowphase", 32'(RowPhase), 32'h5);
      da0Falls(3);
      VMode = 3'd3;
      hsPulse();
      check("shrink_rowphase", 32'(RowPhase), 32'h0);
      check("shrink_vaddr", 32'(VAddr), 32'h0423);
      da0Falls(2);
      hsPulse();
      check("shrink_linebase", 32'(VAddr), 32'h0423);
      check("div2_rowphase1", 32'(RowPhase), 32'h1);
      hsPulse();
      check("div2_end_rowphase", 32'(RowPhase), 32'h0);
      check("div2_end_vaddr", 32'(VAddr), 32'h0423);

      // Divisor 1: every line ends the row
      VMode = 3'd5;
      da0Falls(4);
      hsPulse();
      check("div1_rowphase", 32'(RowPhase), 32'h0);
      check("div1_vaddr", 32'(VAddr), 32'h0427);

      // Offset is ignored until a frame reload
      Offset = 7'h7F;
      da0Falls(1);
      check("offset_midframe", 32'(VAddr), 32'h0428);
      fsPulse();
      check("reload_7f", 32'(VAddr), 32'hFE00);

      // Wrap through 0xFFFF
      strobeBase = strobeCnt;
      da0Falls(512);
      check("wrap_vaddr", 32'(VAddr), 32'h0000);
      check("wrap_strobes", 32'(strobeCnt - strobeBase), 32'd512);

      // FSn + HSn in the same cycle: frame wins
      VMode = 3'd0;
      hsPulse();
      check("prio_pre_vaddr", 32'(VAddr), 32'hFE00);
      check("prio_pre_rowphase", 32'(RowPhase), 32'h1);
      da0Falls(5);
      strobeBase = frameCnt;
      @(negedge Clk);
      FSn = 1'b0;
      HSn = 1'b0;
      repeat (3) @(negedge Clk);
      FSn = 1'b1;
      HSn = 1'b1;
      settle();
      check("prio_fs_vaddr", 32'(VAddr), 32'hFE00);
      check("prio_fs_rowphase", 32'(RowPhase), 32'h0);
      check("prio_fs_framestart", 32'(frameCnt - strobeBase), 32'd1);

      // HSn + DA0 in the same cycle: DA0 dropped
      da0Falls(3);
      @(negedge Clk) DA0 = 1'b1;
      @(negedge Clk);
      strobeBase = strobeCnt;
      HSn = 1'b0;
      DA0 = 1'b0;
      repeat (3) @(negedge Clk);
      HSn = 1'b1;
      settle();
      check("prio_hs_vaddr", 32'(VAddr), 32'hFE00);
      check("prio_hs_rowphase", 32'(RowPhase), 32'h1);
      check("prio_hs_nostrobe", 32'(strobeCnt - strobeBase), 32'd0);

      // Asynchronous reset mid-frame
      @(negedge Clk);
      #2 RSTn = 1'b0;
      #1;
      check("async_rst_vaddr", 32'(VAddr), 32'h0);
      check("async_rst_rowphase", 32'(RowPhase), 32'h0);
      repeat (3) @(negedge Clk);
      RSTn = 1'b1;
      settle();
      da0Falls(3);
      check("post_rst_count", 32'(VAddr), 32'h0003);
      fsPulse();
      check("post_rst_reload", 32'(VAddr), 32'hFE00);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_vdg_address_counter
`default_nettype wire
